// File: rtl/wired_axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master: one read (AR+R) or write (AW+W+B)
// burst at a time, with combinational data paths between the core side and AXI.
module wired_axi_burst_master #(
    parameter logic [3:0] AXI_ID    = 4'd0,
    parameter int         MAX_BEATS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_len,
    input  logic        wdat_valid,
    output logic        wdat_ready,
    input  logic [31:0] wdat_data,
    input  logic [3:0]  wdat_strb,
    output logic        rdat_valid,
    input  logic        rdat_ready,
    output logic [31:0] rdat_data,
    output logic        rdat_last,
    output logic        rdat_err,
    output logic        wresp_valid,
    output logic        wresp_err,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_t;

    localparam logic [3:0] MAX_LEN = 4'(MAX_BEATS - 1);

    state_t      state, state_next;
    logic [31:0] addr_q;
    logic [3:0]  len_q;
    logic [3:0]  cnt;
    logic [3:0]  len_clamped;
    logic        last_beat;
    logic        r_hs;
    logic        w_hs;
    logic        unused_ids;

    // IDs are not needed with a single outstanding transaction.
    assign unused_ids  = ^{rid, bid};
    assign len_clamped = (req_len > MAX_LEN) ? MAX_LEN : req_len;
    assign last_beat   = (cnt == len_q);
    assign r_hs        = (state == R) && rvalid && rdat_ready;
    assign w_hs        = (state == W) && wdat_valid && wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            len_q  <= '0;
            cnt    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                addr_q <= req_addr;
                len_q  <= len_clamped;
            end
            if (state == IDLE)
                cnt <= '0;
            else if (r_hs || w_hs)
                cnt <= cnt + 4'd1;
        end
    end

    always_comb begin
        state_next  = state;
        req_ready   = 1'b0;
        wdat_ready  = 1'b0;
        rdat_valid  = 1'b0;
        rdat_data   = '0;
        rdat_last   = 1'b0;
        rdat_err    = 1'b0;
        wresp_valid = 1'b0;
        wresp_err   = 1'b0;
        arid        = '0;
        araddr      = '0;
        arlen       = '0;
        arsize      = '0;
        arburst     = '0;
        arlock      = 1'b0;
        arcache     = '0;
        arprot      = '0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        awid        = '0;
        awaddr      = '0;
        awlen       = '0;
        awsize      = '0;
        awburst     = '0;
        awlock      = 1'b0;
        awcache     = '0;
        awprot      = '0;
        awvalid     = 1'b0;
        wid         = '0;
        wdata       = '0;
        wstrb       = '0;
        wlast       = 1'b0;
        wvalid      = 1'b0;
        bready      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = ~rst;
                if (req_valid)
                    state_next = req_write ? AW : AR;
            end
            AR: begin
                arvalid = 1'b1;
                arid    = AXI_ID;
                araddr  = addr_q;
                arlen   = {4'b0, len_q};
                arsize  = 3'b010;
                arburst = 2'b01;
                if (arready)
                    state_next = R;
            end
            R: begin
                // rlast is only cross-checked; the local count ends the burst.
                rdat_valid = rvalid;
                rready     = rdat_ready;
                rdat_data  = rdata;
                rdat_last  = last_beat;
                rdat_err   = (rresp != 2'b00) | (rlast != last_beat);
                if (r_hs && last_beat)
                    state_next = IDLE;
            end
            AW: begin
                awvalid = 1'b1;
                awid    = AXI_ID;
                awaddr  = addr_q;
                awlen   = {4'b0, len_q};
                awsize  = 3'b010;
                awburst = 2'b01;
                if (awready)
                    state_next = W;
            end
            W: begin
                wvalid     = wdat_valid;
                wdat_ready = wready;
                wid        = AXI_ID;
                wdata      = wdat_data;
                wstrb      = wdat_strb;
                wlast      = last_beat;
                if (w_hs && last_beat)
                    state_next = B;
            end
            B: begin
                bready = 1'b1;
                if (bvalid) begin
                    wresp_valid = 1'b1;
                    wresp_err   = (bresp != 2'b00);
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/wired_axi_burst_master.md
# wired_axi_burst_master

Single-outstanding AXI4 burst master that sits directly upstream of the top-level AXI pins and downstream of the cache/uncached memory pipeline. It accepts one read or write request at a time from the core's memory side and issues it as one INCR burst: AR + R beats for reads, AW + W beats + B for writes. It streams data between the core-side handshakes and the AXI channels. The `mem` AXI port of the CPU core is driven by this block.

## Interface
Parameters:
- `AXI_ID`, 4'd0, constant value driven on `arid`, `awid`, `wid`.
- `MAX_BEATS`, 16, maximum burst length in beats. `req_len` above `MAX_BEATS-1` is clamped.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid` / `req_ready`  in / out  1  request handshake.
- `req_write`  in  1  1 = write burst, 0 = read burst.
- `req_addr`  in  32  byte address of first beat.
- `req_len`  in  4  beats minus one.
- `wdat_valid` / `wdat_ready`  in / out  1  core write-data handshake.
- `wdat_data`  in  32  write data beat.
- `wdat_strb`  in  4  write byte strobes for the beat.
- `rdat_valid` / `rdat_ready`  out / in  1  read-data return handshake.
- `rdat_data`  out  32  read data beat.
- `rdat_last`  out  1  final beat of the burst.
- `rdat_err`  out  1  beat-level error.
- `wresp_valid`  out  1  one-cycle write-completion pulse.
- `wresp_err`  out  1  qualifies `wresp_valid`; set when `bresp != 0`.
- AXI master signals, 32-bit address and data, 4-bit id: `arid araddr arlen arsize arburst arlock arcache arprot arvalid arready`, `rid rdata rresp rlast rvalid rready`, `awid awaddr awlen awsize awburst awlock awcache awprot awvalid awready`, `wid wdata wstrb wlast wvalid wready`, `bid bresp bvalid bready`.

## Operation
States: IDLE, AR, R, AW, W, B.
- **IDLE**: `req_ready=1`.
  - On handshake, latch addr/len (clamped) and go to AR if `req_write=0`, else AW.
- **AR**: `arvalid=1`, all AR fields stable. Go to R on `arready`.
- **R**: `rdat_valid=rvalid`, `rready=rdat_ready`, `rdat_data=rdata`. Beat counter increments on each R handshake.
  - `rdat_last = (cnt==len)`.
  - `rdat_err = (rresp!=0) | (rlast != (cnt==len))`.
  - Go to IDLE on the handshake with `cnt==len`. `rlast` is only checked, never used to end the burst.
- **AW**: `awvalid=1`. Go to W on `awready`. AW is always completed before any W beat is presented.
- **W**: `wvalid=wdat_valid`, `wdat_ready=wready`, `wdata`/`wstrb` pass through. `wlast = (cnt==len)`.
  - Go to B on the handshake with `cnt==len`.
- **B**: `bready=1`. On `bvalid`, pulse `wresp_valid` for one cycle with `wresp_err = (bresp!=0)`, then go to IDLE.
- Fixed AXI fields:
  - `arsize`/`awsize`: 3'b010.
  - `arburst`/`awburst`: 2'b01 (INCR).
  - `lock`: 0, `cache`: 4'b0000, `prot`: 3'b000.
  - `arlen`/`awlen`: {4'b0, len}.
- Address: `req_addr` is passed unmodified. 4 KB boundary crossing and alignment are the requester's responsibility.
- `rid` and `bid` are ignored. Only one transaction is outstanding at any time.
- All core-side and AXI outputs are 0 outside their owning state.

## Timing
- Reset: state=IDLE, counter=0. Every valid/ready/pulse output is 0 except `req_ready`, which is 1 after reset deasserts. Address/len registers are cleared to 0.
- Reset asserted mid-burst forces IDLE immediately. The AXI slave must be reset in the same domain.
- Read latency, with `arready`, `rvalid` and `rdat_ready` all held high:
  - Cycle 0: request accepted.
  - Cycle 1: `arvalid`.
  - Cycles 2 .. 2+len: one beat per cycle.
  - Cycle 3+len: `req_ready=1` again.
- Write latency, with `awready`, `wready`, `wdat_valid` and `bvalid` all high:
  - Cycle 1: AW.
  - Cycles 2 .. 2+len: W beats.
  - Cycle 3+len: B and `wresp_valid`.
  - Cycle 4+len: IDLE.
- Registered AXI valids stay asserted until handshake, and their payload does not change while waiting.
- Data paths R→rdat and wdat→W are combinational, with zero added latency and no buffering. Backpressure propagates both ways in the same cycle.

## Test plan
- Read, len=3, addr 0x1C000040, slave returns 0xA0..0xA3 with `rlast` on beat 3:
  - `araddr`=0x1C000040, `arlen`=3.
  - Four `rdat` beats 0xA0..0xA3, `rdat_last` on the 4th only, `rdat_err`=0.
  - `req_ready` high at cycle 6.
- Read with `rdat_ready` toggling 1/0:
  - `rready` mirrors `rdat_ready`.
  - No beat is lost or duplicated.
  - `rvalid` held during stalls is accepted exactly once.
- Write, len=1, data 0x11223344 / 0x55667788, strb 0xF / 0x3, with `awready` delayed 3 cycles:
  - No `wvalid` before the AW handshake.
  - `wlast` set on the 2nd beat.
  - `bresp`=0 gives a one-cycle `wresp_valid` with `wresp_err`=0.
- Error cases:
  - Read with `rresp=2'b10` on beat 0 sets `rdat_err` on that beat only.
  - `rlast` asserted early on beat 1 of len=3 sets `rdat_err`. The burst still completes after beat 3.
  - `bresp=2'b11` sets `wresp_err`=1.
- `req_len` handling:
  - With `MAX_BEATS=8`, `req_len=15` gives `arlen=7` and exactly 8 beats.
  - `req_len=0` gives a single beat with `wlast`/`rdat_last` on it.
- Assert `rst` during the W state after 2 beats:
  - All valids and `wdat_ready` drop immediately.
  - After release, `req_ready`=1, and a fresh read completes normally.
